// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column strobing, 2-flop row synchroniser,
// whole-scan debounce and one-cycle key_valid. Define KEYPAD_REPEAT_EN to add auto-repeat.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_RATE    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_SCANS must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] dwell_cnt;
    logic [1:0]    col_idx;
    logic          dwell_last;
    logic [15:0]   col_hits;
    logic [15:0]   key_map;
    logic          scan_done;
    logic [4:0]    n_down;
    logic [3:0]    single_code;
    logic          is_single;
    logic          cand_down;
    logic          rep_fire;
    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] db_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            // NOTE: non-blocking so row_sync takes last cycle's row_meta -- two real flop stages.
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign dwell_last = (dwell_cnt == DWELL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            col_sel   <= 4'b1110;
        end else if (dwell_last) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
            col_sel   <= {col_sel[2:0], col_sel[3]};
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    // Keys seen in the column currently driven, indexed {row, col}.
    always_comb begin
        // NOTE: default first, so every path assigns col_hits and no latch is inferred.
        col_hits = '0;
        for (int r = 0; r < 4; r++) begin
            col_hits[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    // The map restarts with column 0 and is complete for one cycle after column 3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_map   <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= dwell_last && (col_idx == 2'd3);
            if (dwell_last) begin
                key_map <= ((col_idx == 2'd0) ? 16'h0000 : key_map) | col_hits;
            end
        end
    end

    always_comb begin
        n_down      = '0;
        single_code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (key_map[i]) begin
                n_down      = n_down + 5'd1;
                single_code = 4'(i);
            end
        end
    end

    assign is_single = (n_down == 5'd1);
    assign cand_down = key_map[cand];
    assign db_inc    = db_cnt + CW'(1);

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_DELAY + REPEAT_RATE);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_inc;

    assign rep_inc  = rep_cnt + RW'(1);
    assign rep_fire = (state == S_PRESSED) && cand_down &&
                      ((rep_inc == REP_FIRST) || (rep_inc == REP_NEXT));

    // Counts held scans in PRESSED only; folds back to REP_FIRST after each periodic repeat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else if (state != S_PRESSED) begin
            rep_cnt <= '0;
        end else if (scan_done && cand_down) begin
            rep_cnt <= (rep_inc == REP_NEXT) ? REP_FIRST : rep_inc;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cand      <= '0;
            db_cnt    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                unique case (state)
                    S_IDLE: begin
                        if (is_single) begin
                            cand <= single_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= single_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                db_cnt    <= DB_TARGET;
                                state     <= S_PRESSED;
                            end else begin
                                db_cnt <= CW'(1);
                                state  <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (is_single && (single_code == cand)) begin
                            if (db_inc == DB_TARGET) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                db_cnt    <= DB_TARGET;
                                state     <= S_PRESSED;
                            end else begin
                                db_cnt <= db_inc;
                            end
                        end else begin
                            db_cnt <= '0;
                            state  <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        if (!cand_down) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                db_cnt   <= '0;
                                key_held <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                db_cnt <= CW'(1);
                                state  <= S_RELEASE;
                            end
                        end else if (rep_fire) begin
                            key_valid <= 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        if (cand_down) begin
                            db_cnt <= DB_TARGET;
                            state  <= S_PRESSED;
                        end else if (db_inc == DB_TARGET) begin
                            db_cnt   <= '0;
                            key_held <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                    default: begin
                        db_cnt <= '0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a scan-level keypad model, per-cycle output compare,
// and hand-computed checks for each directed scenario.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 2;
    localparam int RD       = 3;
    localparam int RR       = 2;
    localparam int SCAN_LEN = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DS),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_sel  (col_sel),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [15:0] scan_tab[$];
    logic [15:0] pressed = 16'h0000;

    // Model state: what the keypad must report, judged scan by scan.
    logic       m_held;
    logic [3:0] m_code;
    int         m_streak;
    int         m_streak_key;
    int         m_absent;
    int         m_rep;
    logic       m_pulse;
    logic [3:0] exp_col;

    int pulses;
    int first_pulse;
    int pulse_cyc[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [15:0] scan_at(input int s);
        return (s < scan_tab.size()) ? scan_tab[s] : 16'h0000;
    endfunction

    task automatic model_reset();
        m_held       = 1'b0;
        m_code       = 4'h0;
        m_streak     = 0;
        m_streak_key = 0;
        m_absent     = 0;
        m_rep        = 0;
    endtask

    // One completed scan: keys is the set of keys down during it.
    task automatic model_scan(input logic [15:0] keys, output logic pulse);
        int n;
        int k;
        pulse = 1'b0;
        n     = $countones(keys);
        k     = 0;
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) begin
                k = i;
                break;
            end
        end
        if (!m_held) begin
            if (n == 1 && (m_streak == 0 || m_streak_key == k)) begin
                m_streak_key = k;
                m_streak++;
            end else begin
                m_streak = 0;
            end
            if (m_streak == DS) begin
                pulse    = 1'b1;
                m_held   = 1'b1;
                m_code   = 4'(k);
                m_streak = 0;
                m_absent = 0;
                m_rep    = 0;
            end
        end else if (keys[m_code]) begin
            if (m_absent > 0) begin
                m_absent = 0;
                m_rep    = 0;
            end else begin
                m_rep++;
`ifdef KEYPAD_REPEAT_EN
                if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RR == 0)) pulse = 1'b1;
`endif
            end
        end else begin
            m_absent++;
            m_rep = 0;
            if (m_absent == DS) begin
                m_held   = 1'b0;
                m_absent = 0;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Scan s presents its key set from the middle of its first cycle.
    always @(negedge clk) pressed = scan_at(cyc / SCAN_LEN);

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_sel[c] && pressed[{2'(r), 2'(c)}]) row_in[r] = 1'b0;
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            model_reset();
            check("rst_col_sel", {28'h0, col_sel}, 32'hE);
            check("rst_key_valid", {31'h0, key_valid}, 32'h0);
            check("rst_key_held", {31'h0, key_held}, 32'h0);
            check("rst_key_code", {28'h0, key_code}, 32'h0);
        end else begin
            m_pulse = 1'b0;
            if (cyc >= SCAN_LEN + 1 && cyc % SCAN_LEN == 1) begin
                model_scan(scan_at((cyc - SCAN_LEN - 1) / SCAN_LEN), m_pulse);
            end
            exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("col_sel", {28'h0, col_sel}, {28'h0, exp_col});
            check("key_valid", {31'h0, key_valid}, {31'h0, m_pulse});
            check("key_held", {31'h0, key_held}, {31'h0, m_held});
            check("key_code", {28'h0, key_code}, {28'h0, m_code});
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            pulses      = 0;
            first_pulse = -1;
            pulse_cyc.delete();
        end else if (key_valid) begin
            if (pulses == 0) first_pulse = cyc;
            pulses++;
            pulse_cyc.push_back(cyc);
        end
    end

    task automatic wait_cycle(input int n);
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (cyc != n && budget < n + 64);
        check("cycle_reached", cyc, n);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int exp_rep[4];
        exp_rep = '{33, 81, 113, 145};
        reset = 1'b0;
        #1 reset = 1'b1;

        // Hold key 6, glitch release for one scan, then release for two.
        scan_tab = {16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0000,
                    16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0000};
        repeat (2) @(negedge clk);
        check("lit_rst_col", {28'h0, col_sel}, 32'hE);
        check("lit_rst_code", {28'h0, key_code}, 32'h0);
        release_reset();
        wait_cycle(4);   check("lit_col_4", {28'h0, col_sel}, 32'hD);
        wait_cycle(8);   check("lit_col_8", {28'h0, col_sel}, 32'hB);
        wait_cycle(12);  check("lit_col_12", {28'h0, col_sel}, 32'h7);
        wait_cycle(16);  check("lit_col_16", {28'h0, col_sel}, 32'hE);
        wait_cycle(20);  check("lit_col_20", {28'h0, col_sel}, 32'hD);
        wait_cycle(40);
        check("lit_hold_pulses", pulses, 1);
        check("lit_hold_first", first_pulse, 33);
        check("lit_hold_code", {28'h0, key_code}, 32'h6);
        check("lit_hold_held", {31'h0, key_held}, 32'h1);
        wait_cycle(100); check("lit_glitch_held", {31'h0, key_held}, 32'h1);
        wait_cycle(144); check("lit_held_144", {31'h0, key_held}, 32'h1);
        wait_cycle(145); check("lit_held_145", {31'h0, key_held}, 32'h0);
        wait_cycle(170); check("lit_glitch_pulses", pulses, 1);

        // Bounce of key 3 for one scan, then a clean two-scan press.
        assert_reset();
        scan_tab = {16'h0008, 16'h0000, 16'h0008, 16'h0008, 16'h0000, 16'h0000};
        release_reset();
        wait_cycle(60);  check("lit_bounce_pulses", pulses, 0);
        wait_cycle(70);
        check("lit_after_bounce_pulses", pulses, 1);
        check("lit_after_bounce_first", first_pulse, 65);
        check("lit_after_bounce_code", {28'h0, key_code}, 32'h3);
        wait_cycle(110); check("lit_after_bounce_held", {31'h0, key_held}, 32'h0);

        // Keys 0 and 5 together for four scans.
        assert_reset();
        scan_tab = {16'h0021, 16'h0021, 16'h0021, 16'h0021, 16'h0000};
        release_reset();
        wait_cycle(100);
        check("lit_multi_pulses", pulses, 0);
        check("lit_multi_held", {31'h0, key_held}, 32'h0);

        // Accept 6, release, then reset part-way through debouncing key 9.
        assert_reset();
        scan_tab = {16'h0040, 16'h0040, 16'h0000, 16'h0000,
                    16'h0200, 16'h0200, 16'h0200, 16'h0200};
        release_reset();
        wait_cycle(85);
        check("lit_pre_rst_code", {28'h0, key_code}, 32'h6);
        check("lit_pre_rst_held", {31'h0, key_held}, 32'h0);
        wait_cycle(88);
        #2 reset = 1'b1;
        @(negedge clk);
        check("lit_mid_rst_code", {28'h0, key_code}, 32'h0);
        check("lit_mid_rst_col", {28'h0, col_sel}, 32'hE);
        scan_tab = {16'h0200, 16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h0000};
        release_reset();
        wait_cycle(20);  check("lit_k9_early_pulses", pulses, 0);
        wait_cycle(40);
        check("lit_k9_pulses", pulses, 1);
        check("lit_k9_first", first_pulse, 33);
        check("lit_k9_code", {28'h0, key_code}, 32'h9);
        wait_cycle(120); check("lit_k9_held", {31'h0, key_held}, 32'h0);

        // Key 6 held for ten scans: one pulse, or accept plus repeats when enabled.
        assert_reset();
        scan_tab = {16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040,
                    16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040,
                    16'h0000, 16'h0000, 16'h0000};
        release_reset();
        wait_cycle(200);
        check("lit_long_held", {31'h0, key_held}, 32'h0);
        check("lit_long_code", {28'h0, key_code}, 32'h6);
`ifdef KEYPAD_REPEAT_EN
        check("lit_rep_pulses", pulses, 4);
        for (int i = 0; i < 4; i++) begin
            check("lit_rep_cycle", (i < pulse_cyc.size()) ? pulse_cyc[i] : -1, exp_rep[i]);
        end
`else
        check("lit_norep_pulses", pulses, 1);
        check("lit_norep_first", first_pulse, exp_rep[0]);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
